// File: rtl/pll_ctrl_pkg.sv
// Shared types and default timing for the PLL reset controller.
// State encoding, output bundle and default cycle counts live here.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } pll_state_e;

  localparam int DEF_HOLD_CYCLES    = 16;
  localparam int DEF_STABLE_CYCLES  = 256;
  localparam int DEF_TIMEOUT_CYCLES = 4096;
  localparam int DEF_MAX_RETRIES    = 3;
  localparam int RETRY_W            = 3;

  typedef struct packed {
    logic pll_resetb;
    logic pll_bypass;
    logic sys_resetn;
    logic locked;
    logic fail;
  } pll_outs_t;

  // Output levels for a given state; bypass_en selects the reference-clock fallback in FAIL.
  function automatic pll_outs_t state_outs(input pll_state_e s, input logic bypass_en);
    pll_outs_t o;
    o = '0;
    case (s)
      ST_HOLD: begin
        o.pll_resetb = 1'b0;
      end
      ST_WAIT_LOCK, ST_STABLE: begin
        o.pll_resetb = 1'b1;
      end
      ST_RUN: begin
        o.pll_resetb = 1'b1;
        o.sys_resetn = 1'b1;
        o.locked     = 1'b1;
      end
      ST_FAIL: begin
        o.pll_resetb = 1'b0;
        o.fail       = 1'b1;
        o.pll_bypass = bypass_en;
        o.sys_resetn = bypass_en;
      end
      default: begin
        o = '0;
      end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pll_reset_ctrl_sync_2ff.sv
// Two-flop synchronizer bringing the raw PLL lock into the reference clock domain.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: hold, wait for lock, qualify lock, run, give up after retries.
// Optional macro PLL_BYPASS_FALLBACK_EN runs downstream logic on the reference clock in FAIL.
module pll_reset_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
  input  logic               REFERENCECLK,
  input  logic               RESET,
  input  logic               PLL_LOCK,
  input  logic               RESTART,
  output logic               PLL_RESETB,
  output logic               PLL_BYPASS,
  output logic               SYS_RESETN,
  output logic               LOCKED,
  output logic               FAIL,
  output logic [RETRY_W-1:0] RETRY_CNT,
  output pll_state_e         STATE_DBG
);

`ifdef PLL_BYPASS_FALLBACK_EN
  localparam logic BYPASS_EN = 1'b1;
`else
  localparam logic BYPASS_EN = 1'b0;
`endif

  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int SW = $clog2(STABLE_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  localparam logic [HW-1:0]      HOLD_LAST   = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0]      STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [SW-1:0]      STABLE_ONE  = SW'(1);
  localparam logic [TW-1:0]      TO_LAST     = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);
  localparam logic [RETRY_W-1:0] RETRY_SAT   = {RETRY_W{1'b1}};

  logic                lock_s;
  pll_state_e          state;
  pll_outs_t           outs;
  logic [HW-1:0]       hold_cnt;
  logic [SW-1:0]       stable_cnt;
  logic [TW-1:0]       to_cnt;
  logic [RETRY_W-1:0]  retry;
  logic [RETRY_W-1:0]  retry_inc;

  sync_2ff u_sync (
    .clk   (REFERENCECLK),
    .rst_n (RESET),
    .d     (PLL_LOCK),
    .q     (lock_s)
  );

  assign retry_inc = (retry == RETRY_SAT) ? retry : retry + 1'b1;

  // RESTART is a one-cycle request sampled on the clock edge; it has no
  // acknowledge and overrides every other transition in the cycle it is seen.
  // Outputs are loaded together with the state so they never decode glitches.
  always_ff @(posedge REFERENCECLK or negedge RESET) begin
    if (!RESET) begin
      state      <= ST_HOLD;
      outs       <= '0;
      hold_cnt   <= '0;
      stable_cnt <= '0;
      to_cnt     <= '0;
      retry      <= '0;
    end else if (RESTART) begin
      state      <= ST_HOLD;
      outs       <= state_outs(ST_HOLD, BYPASS_EN);
      hold_cnt   <= '0;
      stable_cnt <= '0;
      to_cnt     <= '0;
      retry      <= '0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state    <= ST_WAIT_LOCK;
            outs     <= state_outs(ST_WAIT_LOCK, BYPASS_EN);
            hold_cnt <= '0;
            to_cnt   <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        ST_WAIT_LOCK: begin
          if (lock_s) begin
            // The lock sample seen here is the first of the qualifying run.
            state      <= ST_STABLE;
            outs       <= state_outs(ST_STABLE, BYPASS_EN);
            stable_cnt <= STABLE_ONE;
          end else if (to_cnt == TO_LAST) begin
            to_cnt <= '0;
            retry  <= retry_inc;
            if (retry_inc == RETRY_MAX) begin
              state <= ST_FAIL;
              outs  <= state_outs(ST_FAIL, BYPASS_EN);
            end else begin
              state <= ST_HOLD;
              outs  <= state_outs(ST_HOLD, BYPASS_EN);
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        ST_STABLE: begin
          if (!lock_s) begin
            // Timeout budget of this attempt keeps what was already spent.
            state      <= ST_WAIT_LOCK;
            outs       <= state_outs(ST_WAIT_LOCK, BYPASS_EN);
            stable_cnt <= '0;
          end else if (stable_cnt == STABLE_LAST) begin
            state      <= ST_RUN;
            outs       <= state_outs(ST_RUN, BYPASS_EN);
            stable_cnt <= '0;
            retry      <= '0;
          end else begin
            stable_cnt <= stable_cnt + 1'b1;
          end
        end

        ST_RUN: begin
          if (!lock_s) begin
            state    <= ST_HOLD;
            outs     <= state_outs(ST_HOLD, BYPASS_EN);
            hold_cnt <= '0;
          end
        end

        ST_FAIL: begin
          state <= ST_FAIL;
          outs  <= state_outs(ST_FAIL, BYPASS_EN);
        end

        default: begin
          state      <= ST_HOLD;
          outs       <= state_outs(ST_HOLD, BYPASS_EN);
          hold_cnt   <= '0;
          stable_cnt <= '0;
          to_cnt     <= '0;
        end
      endcase
    end
  end

  assign PLL_RESETB = outs.pll_resetb;
  assign PLL_BYPASS = outs.pll_bypass;
  assign SYS_RESETN = outs.sys_resetn;
  assign LOCKED     = outs.locked;
  assign FAIL       = outs.fail;
  assign RETRY_CNT  = retry;
  assign STATE_DBG  = state;

endmodule

// File: doc/pll_reset_ctrl.md
PLL_RESET_CTRL -- requirements
Module: pll_reset_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 16, cycles PLL reset is held low per attempt (>=2).
REQ-002 SHALL have parameter STABLE_CYCLES, default 256, consecutive synchronized-lock cycles required before release (>=2).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096, maximum cycles waiting for lock per attempt (>HOLD_CYCLES).
REQ-004 SHALL have parameter MAX_RETRIES, default 3, timed-out attempts tolerated before FAIL (1..7).
REQ-005 SHALL have port REFERENCECLK  input  1  sole clock, PLL reference clock.
REQ-006 SHALL have port RESET  input  1  asynchronous active-low reset.
REQ-007 SHALL have port PLL_LOCK  input  1  raw PLL LOCK, asynchronous to REFERENCECLK.
REQ-008 SHALL have port RESTART  input  1  single-cycle request to re-sequence the PLL.
REQ-009 SHALL have port PLL_RESETB  output  1  drives PLL RESETB, active low.
REQ-010 SHALL have port PLL_BYPASS  output  1  drives PLL BYPASS.
REQ-011 SHALL have port SYS_RESETN  output  1  active-low reset for logic clocked by the PLL output.
REQ-012 SHALL have port LOCKED  output  1  high while in RUN.
REQ-013 SHALL have port FAIL  output  1  high while in FAIL.
REQ-014 SHALL have port RETRY_CNT  output  3  timed-out attempts since last clear.

Function
REQ-015 SHALL pass PLL_LOCK through a 2-flop synchronizer; all lock decisions use the synchronized value (lock_s).
REQ-016 SHALL implement states HOLD, WAIT_LOCK, STABLE, RUN, FAIL; all outputs registered, derived from state.
REQ-017 HOLD: PLL_RESETB=0, SYS_RESETN=0; after exactly HOLD_CYCLES cycles SHALL go to WAIT_LOCK.
REQ-018 WAIT_LOCK: PLL_RESETB=1; lock_s=1 -> STABLE; TIMEOUT_CYCLES elapsed without lock -> RETRY_CNT+1, then FAIL if new count equals MAX_RETRIES, else HOLD.
REQ-019 STABLE: lock_s=1 for STABLE_CYCLES consecutive cycles -> RUN; lock_s=0 at any point -> WAIT_LOCK with stable counter cleared, timeout counter NOT cleared.
REQ-020 RUN: SYS_RESETN=1, LOCKED=1, RETRY_CNT cleared on entry; lock_s=0 -> HOLD with SYS_RESETN low in the next cycle.
REQ-021 FAIL: PLL_RESETB=0, FAIL=1; exit only via RESTART or RESET.
REQ-022 RESTART SHALL take priority over every other transition: any state -> HOLD, RETRY_CNT cleared, counters cleared.
REQ-023 SYS_RESETN rise SHALL occur in the cycle after the last STABLE cycle; no glitch on any output.
REQ-024 Counters SHALL be sized by $clog2 of their parameter and SHALL saturate, never wrap.

Reset
REQ-025 On RESET low: state HOLD, all counters 0, synchronizer flops 0, PLL_RESETB=0, PLL_BYPASS=0, SYS_RESETN=0, LOCKED=0, FAIL=0, RETRY_CNT=0.
REQ-026 Release of RESET SHALL start a full HOLD interval; RESET mid-operation SHALL drop SYS_RESETN immediately (asynchronously).

Configuration
REQ-027 With PLL_BYPASS_FALLBACK_EN defined: in FAIL, PLL_BYPASS=1 and SYS_RESETN=1 (logic runs on reference clock), LOCKED=0.
REQ-028 Without PLL_BYPASS_FALLBACK_EN: PLL_BYPASS tied 0; SYS_RESETN=0 in FAIL.

Structure
REQ-029 State enum and default timing constants SHALL live in shared package pll_ctrl_pkg.
REQ-030 The 2-flop synchronizer SHALL be sub-module sync_2ff; FSM and counters stay in pll_reset_ctrl.

Verification (HOLD=4, STABLE=8, TIMEOUT=32, MAX_RETRIES=2)
REQ-031 Reset release, PLL_LOCK high from cycle 10 -> PLL_RESETB high at cycle 4; SYS_RESETN and LOCKED high 8 cycles after lock_s rises; RETRY_CNT=0.
REQ-032 PLL_LOCK never high -> two 32-cycle timeouts, RETRY_CNT 1 then 2, FAIL=1, PLL_RESETB=0; with macro PLL_BYPASS=1, SYS_RESETN=1; without, both 0.
REQ-033 Lock glitch low for 1 cycle during STABLE -> return to WAIT_LOCK; SYS_RESETN rises only after 8 further continuous lock cycles.
REQ-034 Lock drop in RUN -> SYS_RESETN low next cycle after lock_s falls, PLL_RESETB low for 4 cycles, then re-lock reaches RUN.
REQ-035 RESTART pulse in FAIL and in RUN -> HOLD next cycle, RETRY_CNT=0, FAIL=0, PLL_BYPASS=0.
REQ-036 RESET asserted mid-STABLE -> all outputs at reset values without a clock edge.
